// File: rtl/adpll_lock_seq_pkg.sv
// Shared types and constants for the ADPLL lock sequencer.
// Build option ADPLL_LOCK_STATS_EN is consumed by the top, not by this package.
package adpll_seq_pkg;

  typedef enum logic [1:0] {
    HOLD   = 2'd0,
    SEARCH = 2'd1,
    SETTLE = 2'd2,
    LOCKED = 2'd3
  } seq_state_e;

  localparam logic [2:0] M_MIN = 3'd1;
  localparam logic [2:0] M_MAX = 3'd7;

  // A divider ratio is usable when it is non-zero; 3 bits cannot exceed M_MAX.
  function automatic logic m_req_ok(input logic [2:0] m);
    return (m >= M_MIN);
  endfunction

endpackage

// File: rtl/adpll_lock_seq_if.sv
// Host-side divider-ratio request channel (valid/ready) for adpll_lock_seq.
interface adpll_lock_seq_if;

  logic [2:0] m_req;
  logic       m_req_valid;
  logic       m_req_ready;

  modport master (
    output m_req,
    output m_req_valid,
    input  m_req_ready
  );

  modport slave (
    input  m_req,
    input  m_req_valid,
    output m_req_ready
  );

endinterface

// File: rtl/adpll_loss_det.sv
// Loss-of-lock detector: decodes PFD flags and counts consecutive same-direction
// non-quiet cycles; loss is raised combinationally on the cycle the run hits LOSS_CNT.
module adpll_loss_det #(
  parameter int LOSS_CNT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic flagU,
  input  logic flagD,
  output logic loss
);

  localparam int LW = $clog2(LOSS_CNT + 1);

  logic          w_quiet;
  logic          w_up;
  logic          w_dn;
  logic          w_same;
  logic [LW-1:0] w_lcnt_nxt;
  logic [LW-1:0] r_lcnt;
  logic          r_dir_up;

  assign w_quiet = (flagU == flagD);
  assign w_up    = flagU & ~flagD;
  assign w_dn    = flagD & ~flagU;
  assign w_same  = (w_up & r_dir_up) | (w_dn & ~r_dir_up);

  // Run-length update: quiet holds, same direction extends (saturating), a flip restarts at 1.
  always_comb begin
    w_lcnt_nxt = r_lcnt;
    if (!en) begin
      w_lcnt_nxt = '0;
    end else if (w_quiet) begin
      w_lcnt_nxt = r_lcnt;
    end else if (w_same && (r_lcnt != '0)) begin
      if (r_lcnt < LW'(LOSS_CNT)) begin
        w_lcnt_nxt = r_lcnt + LW'(1);
      end else begin
        w_lcnt_nxt = r_lcnt;
      end
    end else begin
      w_lcnt_nxt = LW'(1);
    end
  end

  assign loss = en & ~w_quiet & (w_lcnt_nxt == LW'(LOSS_CNT));

  // Run counter and last non-quiet direction; cleared while the detector is disabled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lcnt   <= '0;
      r_dir_up <= 1'b0;
    end else begin
      r_lcnt <= w_lcnt_nxt;
      if (en && !w_quiet) begin
        r_dir_up <= w_up;
      end else begin
        r_dir_up <= r_dir_up;
      end
    end
  end

endmodule

// File: rtl/adpll_lock_seq.sv
// ADPLL lock sequencer: HOLD -> SEARCH -> SETTLE -> LOCKED with automatic re-lock.
// Define ADPLL_LOCK_STATS_EN to add the saturating relock_cnt output.
module adpll_lock_seq
  import adpll_seq_pkg::*;
#(
  parameter int         HOLD_CYC   = 4,
  parameter int         SEARCH_TO  = 255,
  parameter int         SETTLE_CNT = 16,
  parameter int         LOSS_CNT   = 8,
  parameter int         CW         = 8,
  parameter logic [2:0] M_DEFAULT  = 3'd4
) (
  input  logic                    clk,
  input  logic                    reset,
  adpll_lock_seq_if.slave         req_if,
  input  logic                    freq_lock,
  input  logic                    flagU,
  input  logic                    flagD,
  output logic [2:0]              M,
  output logic                    ctrl_reset_n,
  output logic                    locked,
  output logic                    lock_lost,
  output logic                    search_fail,
  output logic                    m_err
`ifdef ADPLL_LOCK_STATS_EN
  ,
  output logic [7:0]              relock_cnt
`endif
);

  seq_state_e r_state;
  seq_state_e w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [2:0]    r_m;
  logic [2:0]    w_m_nxt;
  logic          r_ctrl_rst_n;
  logic          r_locked;
  logic          w_locked_nxt;
  logic          r_lock_lost;
  logic          w_lost_nxt;
  logic          r_search_fail;
  logic          w_fail_nxt;
  logic          r_m_err;
  logic          w_err_nxt;
  logic          w_clr_stats;
  logic          w_ready;
  logic          w_accept;
  logic          w_quiet;
  logic          w_loss_en;
  logic          w_loss;

  assign w_ready            = (r_state == SEARCH) || (r_state == LOCKED);
  assign req_if.m_req_ready = w_ready;
  assign w_accept           = req_if.m_req_valid & w_ready;
  assign w_quiet            = (flagU == flagD);
  assign w_loss_en          = (r_state == LOCKED);

  adpll_loss_det #(
    .LOSS_CNT (LOSS_CNT)
  ) u_loss_det (
    .clk   (clk),
    .reset (reset),
    .en    (w_loss_en),
    .flagU (flagU),
    .flagD (flagD),
    .loss  (w_loss)
  );

  // Next-state and next-output logic; an accepted non-zero request overrides everything.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_m_nxt      = r_m;
    w_locked_nxt = r_locked;
    w_lost_nxt   = 1'b0;
    w_fail_nxt   = 1'b0;
    w_err_nxt    = 1'b0;
    w_clr_stats  = 1'b0;
    case (r_state)
      HOLD: begin
        if (r_cnt == CW'(HOLD_CYC - 1)) begin
          w_state_nxt = SEARCH;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      SEARCH: begin
        if (freq_lock) begin
          w_state_nxt = SETTLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CW'(SEARCH_TO)) begin
          w_state_nxt = HOLD;
          w_cnt_nxt   = '0;
          w_fail_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      SETTLE: begin
        if (!freq_lock) begin
          w_state_nxt = HOLD;
          w_cnt_nxt   = '0;
        end else if (!w_quiet) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == CW'(SETTLE_CNT - 1)) begin
          w_state_nxt  = LOCKED;
          w_cnt_nxt    = '0;
          w_locked_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      LOCKED: begin
        if (w_loss || !freq_lock) begin
          w_state_nxt  = HOLD;
          w_cnt_nxt    = '0;
          w_locked_nxt = 1'b0;
          w_lost_nxt   = 1'b1;
        end else begin
          w_state_nxt = LOCKED;
        end
      end
      default: begin
        w_state_nxt  = HOLD;
        w_cnt_nxt    = '0;
        w_locked_nxt = 1'b0;
      end
    endcase
    if (w_accept) begin
      if (m_req_ok(req_if.m_req)) begin
        w_m_nxt      = req_if.m_req;
        w_locked_nxt = 1'b0;
        w_state_nxt  = HOLD;
        w_cnt_nxt    = '0;
        w_lost_nxt   = 1'b0;
        w_fail_nxt   = 1'b0;
        w_clr_stats  = 1'b1;
      end else begin
        w_err_nxt = 1'b1;
      end
    end else begin
      w_clr_stats = 1'b0;
    end
  end

  // Sequencer state and registered outputs; controller reset follows the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= HOLD;
      r_cnt         <= '0;
      r_m           <= M_DEFAULT;
      r_ctrl_rst_n  <= 1'b0;
      r_locked      <= 1'b0;
      r_lock_lost   <= 1'b0;
      r_search_fail <= 1'b0;
      r_m_err       <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_m           <= w_m_nxt;
      r_ctrl_rst_n  <= (w_state_nxt != HOLD);
      r_locked      <= w_locked_nxt;
      r_lock_lost   <= w_lost_nxt;
      r_search_fail <= w_fail_nxt;
      r_m_err       <= w_err_nxt;
    end
  end

  assign M            = r_m;
  assign ctrl_reset_n = r_ctrl_rst_n;
  assign locked       = r_locked;
  assign lock_lost    = r_lock_lost;
  assign search_fail  = r_search_fail;
  assign m_err        = r_m_err;

`ifdef ADPLL_LOCK_STATS_EN
  logic [7:0] r_relock_cnt;

  // Failure counter: bumps with each lock_lost/search_fail pulse, saturates, cleared by a new M.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_relock_cnt <= 8'd0;
    end else if (w_clr_stats) begin
      r_relock_cnt <= 8'd0;
    end else if ((w_lost_nxt || w_fail_nxt) && (r_relock_cnt != 8'd255)) begin
      r_relock_cnt <= r_relock_cnt + 8'd1;
    end else begin
      r_relock_cnt <= r_relock_cnt;
    end
  end

  assign relock_cnt = r_relock_cnt;
`else
  logic w_unused_stats;
  assign w_unused_stats = w_clr_stats;
`endif

endmodule
